// File: rtl/radix_4_divider_pkg.sv
// Shared types for the radix-4 restoring divider.
// FSM state enum, default width and quotient digit type.
package radix_4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_DEF = 8;

  typedef logic [1:0] digit_t;

endpackage

// File: rtl/radix_4_divider_if.sv
// Operand/result bundle of the radix-4 divider.
// master drives operands, slave returns results.
interface radix_4_divider_if #(
  parameter int N = 8
) ();

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           error;
  logic           ready;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, error, ready
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, error, ready
  );

endinterface

// File: rtl/radix_4_divider_digit.sv
// Radix-4 digit select: largest k in 0..3 with k*d <= partial,
// plus the reduced remainder partial - k*d.
module radix_4_div_digit
  import radix_4_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N+1:0] partial_i,
  input  logic [N-1:0] d_i,
  input  logic [N:0]   d2_i,
  input  logic [N+1:0] d3_i,
  output digit_t       digit_o,
  output logic [N-1:0] rem_o
);

  logic ge3;
  logic ge2;
  logic ge1;

  assign ge3 = partial_i >= d3_i;
  assign ge2 = partial_i >= {1'b0, d2_i};
  assign ge1 = partial_i >= {2'b0, d_i};

  // true difference is < d, so the low N bits are exact
  always_comb begin
    digit_o = 2'd0;
    rem_o   = partial_i[N-1:0];
    priority case (1'b1)
      ge3: begin
        digit_o = 2'd3;
        rem_o   = partial_i[N-1:0] - d3_i[N-1:0];
      end
      ge2: begin
        digit_o = 2'd2;
        rem_o   = partial_i[N-1:0] - d2_i[N-1:0];
      end
      ge1: begin
        digit_o = 2'd1;
        rem_o   = partial_i[N-1:0] - d_i;
      end
      default: begin
        digit_o = 2'd0;
        rem_o   = partial_i[N-1:0];
      end
    endcase
  end

endmodule

// File: rtl/radix_4_divider.sv
// Radix-4 unsigned divider, 2N/N -> N quotient and remainder.
// Define RADIX_4_DIVIDER_BUSY_EN to add the busy output.
module radix_4_divider
  import radix_4_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clock,
  input  logic reset,
`ifdef RADIX_4_DIVIDER_BUSY_EN
  output logic busy,
`endif
  radix_4_divider_if.slave bus
);

  localparam int CW = $clog2(N/2) + 1;
  localparam logic [CW-1:0] LAST = CW'(N/2 - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   d_q, d_d;
  logic [N+1:0]   d3_q, d3_d;
  logic [N-3:0]   qacc_q, qacc_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   remo_q, remo_d;
  logic           err_q, err_d;
  logic           rdy_q, rdy_d;

  logic [N+1:0]   part;
  digit_t         digit;
  logic [N-1:0]   nrem;
  logic [N-1:0]   qnext;
  logic           reject;

  assign part  = {rem_q, dvd_q[N-1:N-2]};
  assign qnext = {qacc_q, digit};

  assign reject = (bus.divisor == '0) ||
                  (bus.dividend[2*N-1:N] >= bus.divisor);

  radix_4_div_digit #(.N(N)) u_digit (
    .partial_i (part),
    .d_i       (d_q),
    .d2_i      ({d_q, 1'b0}),
    .d3_i      (d3_q),
    .digit_o   (digit),
    .rem_o     (nrem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    d_d     = d_q;
    d3_d    = d3_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rdy_d = 1'b0;
          if (reject) begin
            state_d = DONE;
            err_d   = 1'b1;
            quo_d   = '1;
            remo_d  = '0;
            rdy_d   = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = bus.dividend[2*N-1:N];
            dvd_d   = bus.dividend[N-1:0];
            d_d     = bus.divisor;
            // 3d by shift-and-add, kept for the whole run
            d3_d    = {2'b0, bus.divisor} +
                      {1'b0, bus.divisor, 1'b0};
            cnt_d   = '0;
            qacc_d  = '0;
          end
        end
      end
      RUN: begin
        rem_d  = nrem;
        dvd_d  = {dvd_q[N-3:0], 2'b00};
        qacc_d = qnext[N-3:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = qnext;
          remo_d  = nrem;
          err_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      DONE: begin
        if (!bus.start) begin
          state_d = IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      d_q     <= '0;
      d3_q    <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      d_q     <= d_d;
      d3_q    <= d3_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = remo_q;
  assign bus.error     = err_q;
  assign bus.ready     = rdy_q;

`ifdef RADIX_4_DIVIDER_BUSY_EN
  logic busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
    end
  end

  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_radix_4_divider.sv
// Self-checking bench for radix_4_divider (N=8) against an
// arithmetic reference model; honours RADIX_4_DIVIDER_BUSY_EN.
module tb_radix_4_divider;

  localparam int N   = 8;
  localparam int LAT = N/2 + 1;

  logic clock;
  logic reset;
`ifdef RADIX_4_DIVIDER_BUSY_EN
  logic busy;
`endif

  int n_cmp;
  int n_bad;

  radix_4_divider_if #(.N(N)) bus ();

  radix_4_divider #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
`ifdef RADIX_4_DIVIDER_BUSY_EN
    .busy  (busy),
`endif
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference: plain division with the error rules
  task automatic model(input logic [2*N-1:0] dvd,
                       input logic [N-1:0] dvs,
                       output logic [N-1:0] q,
                       output logic [N-1:0] r,
                       output logic e,
                       output int lat);
    int unsigned qq;
    if (dvs == 0) begin
      e = 1'b1; q = '1; r = '0; lat = 1;
    end else begin
      qq = int'(dvd) / int'(dvs);
      if (qq > (2**N - 1)) begin
        e = 1'b1; q = '1; r = '0; lat = 1;
      end else begin
        e   = 1'b0;
        q   = N'(qq);
        r   = N'(int'(dvd) % int'(dvs));
        lat = LAT;
      end
    end
  endtask

  // drive one operation; scramble operands after acceptance
  task automatic run_op(input logic [2*N-1:0] dvd,
                        input logic [N-1:0] dvs,
                        input int start_cycles,
                        output int lat,
                        output int busy_n);
    lat    = -1;
    busy_n = 0;
    @(negedge clock);
    if (bus.ready) @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
`ifdef RADIX_4_DIVIDER_BUSY_EN
      if (busy === 1'b1) busy_n++;
`endif
      if (i == 1) begin
        bus.dividend = (2*N)'($urandom);
        bus.divisor  = N'($urandom);
      end
      if (start_cycles > 0 && i == start_cycles) bus.start = 1'b0;
      if (bus.ready === 1'b1) begin
        lat = i;
        if (start_cycles == 0) bus.start = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_op(input string nm,
                          input logic [2*N-1:0] dvd,
                          input logic [N-1:0] dvs,
                          input int start_cycles);
    logic [N-1:0] eq, er;
    logic ee;
    int el, lat, bn;
    model(dvd, dvs, eq, er, ee, el);
    run_op(dvd, dvs, start_cycles, lat, bn);
    n_cmp++;
    if (lat !== el) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", nm, lat, el);
    end
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.error} !== {eq, er, ee}) begin
      n_bad++;
      $display("FAIL %s result got q=%0d r=%0d e=%0b want q=%0d r=%0d e=%0b",
               nm, bus.quotient, bus.remainder, bus.error, eq, er, ee);
    end
`ifdef RADIX_4_DIVIDER_BUSY_EN
    n_cmp++;
    if (bn !== (ee ? 0 : N/2)) begin
      n_bad++;
      $display("FAIL %s busy cycles got %0d want %0d", nm, bn,
               ee ? 0 : N/2);
    end
`endif
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.error, bus.ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got q=%0d r=%0d e=%0b rdy=%0b want 0",
               bus.quotient, bus.remainder, bus.error, bus.ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    check_op("d1197_57", 16'd1197, 8'd57, 3);
    repeat (4) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.ready !== 1'b0) begin
        n_bad++;
        $display("FAIL single_op ready got %0b want 0", bus.ready);
      end
    end
    check_op("d1000_7", 16'd1000, 8'd7, 0);
    check_op("dFEFF_255", 16'hFEFF, 8'd255, 0);
    check_op("d0_1", 16'd0, 8'd1, 0);
    check_op("d00FF_1", 16'h00FF, 8'd1, 0);
  endtask

  task automatic test_error();
    logic [N-1:0] dvs;
    logic [N-1:0] hi;
    check_op("e255_0", 16'd255, 8'd0, 0);
    check_op("e3900_39", 16'h3900, 8'h39, 0);
    check_op("eFFFF_FF", 16'hFFFF, 8'hFF, 0);
    for (int i = 0; i < 20; i++) begin
      dvs = N'($urandom_range(0, 255));
      hi  = N'($urandom_range(int'(dvs), 255));
      check_op("e_rand", {hi, N'($urandom)}, dvs, 0);
    end
  endtask

  task automatic test_start_held();
    logic [N-1:0] q0;
    check_op("held", 16'd5000, 8'd77, 99);
    q0 = bus.quotient;
    repeat (3) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if ({bus.ready, bus.quotient} !== {1'b1, 8'd64}) begin
        n_bad++;
        $display("FAIL held_done got rdy=%0b q=%0d want rdy=1 q=64",
                 bus.ready, bus.quotient);
      end
    end
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if ({bus.ready, bus.quotient} !== {1'b0, q0}) begin
        n_bad++;
        $display("FAIL held_release got rdy=%0b q=%0d want rdy=0 q=%0d",
                 bus.ready, bus.quotient, q0);
      end
    end
  endtask

  task automatic test_reset_run();
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 16'd4321;
    bus.divisor  = 8'd99;
    repeat (3) @(posedge clock);
    #1;
    bus.start = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.quotient, bus.remainder, bus.error, bus.ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_run got q=%0d r=%0d e=%0b rdy=%0b want 0",
               bus.quotient, bus.remainder, bus.error, bus.ready);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_abort ready got %0b want 0", bus.ready);
      end
    end
    check_op("after_reset", 16'd1000, 8'd7, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] dvs;
    logic [N-1:0] hi;
    logic [2*N-1:0] dvd;
    for (int i = 0; i < 10000; i++) begin
      dvs = N'($urandom_range(1, 255));
      hi  = N'($urandom_range(0, int'(dvs) - 1));
      dvd = {hi, N'($urandom)};
      check_op("rand", dvd, dvs, 0);
      n_cmp++;
      if (int'(dvd) != int'(bus.quotient) * int'(dvs) + int'(bus.remainder)
          || bus.remainder >= dvs) begin
        n_bad++;
        $display("FAIL rand_identity got q=%0d r=%0d want dvd=%0d dvs=%0d",
                 bus.quotient, bus.remainder, dvd, dvs);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_error();
    test_start_held();
    test_reset_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
